move_input_cond: RTL and testbench
==================================

# move_input_cond

Conditions the four movement switches and the start button before they reach the Frogger control logic. Each raw input is synchronized, debounced and, for the movement inputs, converted into single-cycle move pulses. Simultaneous presses are arbitrated so that at most one move pulse is issued per cycle, and optional auto-repeat is provided while a switch is held. The block sits between the board switch pins and `frogger_ctrl`/`frogger_game`, replacing direct use of raw switch levels.

## Interface
- `c_DEBOUNCE_LIMIT`, default 250000: consecutive stable cycles required before a debounced state flips (10 ms at 25 MHz); must be ≥ 1.
- `c_REPEAT_DELAY`, default 12500000: cycles from the first pulse to the first repeat pulse.
- `c_REPEAT_RATE`, default 5000000: cycles between subsequent repeat pulses.
- `i_Clk`  in  1  pixel/system clock.
- `i_Reset`  in  1  synchronous, active-high reset.
- `i_Game_Start`  in  1  raw start button, asynchronous.
- `i_Up_Mvt`, `i_Down_Mvt`, `i_Left_Mvt`, `i_Right_Mvt`  in  1 each  raw switches, asynchronous, active-high.
- `i_Enable`  in  1  movement enabled (game active); synchronous.
- `o_Up_Pulse`, `o_Down_Pulse`, `o_Left_Pulse`, `o_Right_Pulse`  out  1 each  one-cycle move strobes; one-hot or all zero.
- `o_Start_Pulse`  out  1  one-cycle strobe on a debounced start press.
- `o_Locked`  out  1  high while a direction is owned (FSM not in IDLE).
- `o_Dir_Code`  out  2  locked direction: 0=Up, 1=Down, 2=Left, 3=Right; 0 when unlocked.

## Operation
- Synchronizer: each of the 5 raw inputs passes through 2 flops.
- Debouncer, per input:
  - State register plus a counter of width `$clog2(c_DEBOUNCE_LIMIT+1)`.
  - When the synchronized value equals the state, the counter clears to 0.
  - Otherwise the counter increments. When it reaches `c_DEBOUNCE_LIMIT`, the state flips and the counter clears.
- Start: a rising edge of the debounced start state gives `o_Start_Pulse` for one cycle. It is independent of `i_Enable` and the FSM.
- Move FSM, states IDLE, DELAY, REPEAT. Priority is Up > Down > Left > Right.
  - IDLE: if `i_Enable` and any debounced direction is high, latch the highest-priority one, pulse it, load the timer with `c_REPEAT_DELAY-1`, go to DELAY.
  - A direction already held when entering IDLE fires again; after releasing Up while Right is held, Right pulses.
  - DELAY: if the latched direction is released, go to IDLE with no pulse. If the timer is 0, pulse, load `c_REPEAT_RATE-1`, go to REPEAT. Otherwise decrement.
  - REPEAT: same as DELAY, reloading `c_REPEAT_RATE-1` on each pulse.
  - While locked, non-latched directions are ignored, including higher-priority ones.
  - `i_Enable` low: the FSM is forced to IDLE on the next edge and no move pulses are issued. Debouncers keep running.
- The timer is 24 bits wide, and both parameters must fit. Counting is down-only with no wrap; the reload happens exactly at 0.

## Timing
- All outputs are registered.
- Reset values: every pulse 0, `o_Locked`=0, `o_Dir_Code`=0. All debounced states are 0, all counters are 0, the FSM is IDLE.
- `i_Reset` has priority over all other events in the same cycle. Reset mid-press discards progress.
- A switch held through reset is seen as a new press and pulses `c_DEBOUNCE_LIMIT+3` cycles after reset deasserts.
- Press latency, from the first edge sampling the new raw level to the pulse:
  - 2 cycles synchronizer.
  - `c_DEBOUNCE_LIMIT` cycles debounce.
  - 1 cycle FSM/output register.
  - Total: `c_DEBOUNCE_LIMIT+3`.
- Release latency to IDLE is `c_DEBOUNCE_LIMIT+3` cycles. `o_Locked` falls on that edge.
- First repeat comes `c_REPEAT_DELAY` cycles after the first pulse. Later repeats are spaced `c_REPEAT_RATE` cycles apart.
- A glitch shorter than `c_DEBOUNCE_LIMIT` cycles produces no output.
- Simultaneous debounce completion on several directions: only the highest-priority one pulses.

## Configuration
- `MOVE_AUTO_REPEAT_EN` defined:
  - Auto-repeat behaves as described above.
- `MOVE_AUTO_REPEAT_EN` undefined:
  - The REPEAT state and repeat timer are not compiled in.
  - DELAY waits only for release, giving exactly one pulse per press.
  - `c_REPEAT_DELAY` and `c_REPEAT_RATE` are ignored.

## Test plan
Bench parameters: `c_DEBOUNCE_LIMIT`=4, `c_REPEAT_DELAY`=10, `c_REPEAT_RATE`=5, `MOVE_AUTO_REPEAT_EN` defined.
- Reset, then hold Up from cycle 0 with `i_Enable`=1 -> `o_Up_Pulse`=1 only at cycle 7. `o_Locked`=1 and `o_Dir_Code`=0 from cycle 7. Repeats at cycles 17, 22 and 27.
- 3-cycle high glitch on Left -> no pulse, `o_Locked` stays 0.
- Raise Down and Right on the same cycle -> a single `o_Down_Pulse` and no `o_Right_Pulse`. Releasing Down -> Right pulses one cycle after `o_Locked` falls, and `o_Dir_Code`=3.
- Hold Up with `i_Enable`=0 -> no move pulses. Raise `i_Enable` -> Up pulses on the next edge. Press start at any time -> a single `o_Start_Pulse` 7 cycles after the press.
- Assert `i_Reset` for 1 cycle during REPEAT while Up is still held -> outputs go to 0 on the next edge, and Up pulses again 7 cycles after reset deasserts.
- Rebuild without `MOVE_AUTO_REPEAT_EN` and hold Right for 100 cycles -> exactly one `o_Right_Pulse`, at cycle 7.

Source files
------------

// File: rtl/move_input_cond.sv
// move_input_cond: synchronizes and debounces the Frogger movement switches
// and start button. It turns movement presses into arbitrated single-cycle
// move strobes (Up > Down > Left > Right) and start presses into a start strobe.
// Build option: define MOVE_AUTO_REPEAT_EN to get auto-repeat while a switch
// is held. Without it, each press gives exactly one move pulse.
module move_input_cond #(
    parameter int c_DEBOUNCE_LIMIT = 250000,
    parameter int c_REPEAT_DELAY   = 12500000,
    parameter int c_REPEAT_RATE    = 5000000
) (
    input  logic       i_Clk,
    input  logic       i_Reset,
    input  logic       i_Game_Start,
    input  logic       i_Up_Mvt,
    input  logic       i_Down_Mvt,
    input  logic       i_Left_Mvt,
    input  logic       i_Right_Mvt,
    input  logic       i_Enable,
    output logic       o_Up_Pulse,
    output logic       o_Down_Pulse,
    output logic       o_Left_Pulse,
    output logic       o_Right_Pulse,
    output logic       o_Start_Pulse,
    output logic       o_Locked,
    output logic [1:0] o_Dir_Code
);
    // Inputs are indexed 0=Up, 1=Down, 2=Left, 3=Right, 4=Start.
    localparam int N_IN  = 5;
    localparam int START = 4;
    localparam int CNT_W = $clog2(c_DEBOUNCE_LIMIT + 1);
    localparam logic [CNT_W-1:0] LIMIT_CNT = CNT_W'(c_DEBOUNCE_LIMIT);

`ifdef MOVE_AUTO_REPEAT_EN
    localparam int TMR_W = 24;
    localparam logic [TMR_W-1:0] DELAY_LOAD = TMR_W'(c_REPEAT_DELAY - 1);
    localparam logic [TMR_W-1:0] RATE_LOAD  = TMR_W'(c_REPEAT_RATE - 1);
    typedef enum logic [1:0] {IDLE = 2'd0, DELAY = 2'd1, REPEAT = 2'd2} state_t;
    logic [TMR_W-1:0] timer_q, timer_d;
`else
    typedef enum logic [1:0] {IDLE = 2'd0, DELAY = 2'd1} state_t;
    logic unused_repeat_cfg;
    assign unused_repeat_cfg = ^{c_REPEAT_DELAY, c_REPEAT_RATE};
`endif

    logic [N_IN-1:0]  raw_in;
    logic [N_IN-1:0]  sync1_q, sync1_d, sync2_q, sync2_d;
    logic [N_IN-1:0]  deb_q, deb_d;
    logic [CNT_W-1:0] cnt_q [N_IN];
    logic [CNT_W-1:0] cnt_d [N_IN];
    logic             start_prev_q, start_prev_d;
    logic             start_pulse_q, start_pulse_d;
    state_t           state_q, state_d;
    logic [1:0]       dir_q, dir_d;
    logic [3:0]       move_pulse_q, move_pulse_d;
    logic             locked_q, locked_d;
    logic [1:0]       code_q, code_d;
    logic [3:0]       dir_held;
    logic             any_held;
    logic [1:0]       pri_code;

    assign raw_in   = {i_Game_Start, i_Right_Mvt, i_Left_Mvt, i_Down_Mvt, i_Up_Mvt};
    assign dir_held = deb_q[3:0];

    // Two-flop synchronizer and a stability counter per input; a state flips only after a long enough disagreement
    always_comb begin
        sync1_d = raw_in;
        sync2_d = sync1_q;
        deb_d   = deb_q;
        for (int i = 0; i < N_IN; i++) begin
            cnt_d[i] = '0;
            if (sync2_q[i] != deb_q[i]) begin
                if (cnt_q[i] == LIMIT_CNT) begin
                    deb_d[i] = ~deb_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_W'(1);
                end
            end
        end
    end

    // Rising edge of the debounced start level, delayed one cycle to stay fully registered
    always_comb begin
        start_prev_d  = deb_q[START];
        start_pulse_d = deb_q[START] & ~start_prev_q;
    end

    // Highest-priority held direction: Up > Down > Left > Right
    always_comb begin
        any_held = |dir_held;
        if (dir_held[0]) begin
            pri_code = 2'd0;
        end else if (dir_held[1]) begin
            pri_code = 2'd1;
        end else if (dir_held[2]) begin
            pri_code = 2'd2;
        end else begin
            pri_code = 2'd3;
        end
    end

    // Move FSM: claim a direction, pulse it, optionally repeat, release when the owned switch lets go
    always_comb begin
        state_d      = state_q;
        dir_d        = dir_q;
        move_pulse_d = '0;
`ifdef MOVE_AUTO_REPEAT_EN
        timer_d      = timer_q;
`endif
        if (!i_Enable) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (any_held) begin
                        dir_d                  = pri_code;
                        move_pulse_d[pri_code] = 1'b1;
                        state_d                = DELAY;
`ifdef MOVE_AUTO_REPEAT_EN
                        timer_d                = DELAY_LOAD;
`endif
                    end
                end
`ifdef MOVE_AUTO_REPEAT_EN
                DELAY, REPEAT: begin
                    if (!dir_held[dir_q]) begin
                        state_d = IDLE;
                    end else if (timer_q == '0) begin
                        move_pulse_d[dir_q] = 1'b1;
                        timer_d             = RATE_LOAD;
                        state_d             = REPEAT;
                    end else begin
                        timer_d = timer_q - TMR_W'(1);
                    end
                end
`else
                DELAY: begin
                    if (!dir_held[dir_q]) begin
                        state_d = IDLE;
                    end
                end
`endif
                default: state_d = IDLE;
            endcase
        end
        locked_d = (state_d != IDLE);
        code_d   = locked_d ? dir_d : 2'd0;
    end

    // All state and output registers, cleared together by the synchronous reset
    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            sync1_q       <= '0;
            sync2_q       <= '0;
            deb_q         <= '0;
            for (int i = 0; i < N_IN; i++) begin
                cnt_q[i] <= '0;
            end
            start_prev_q  <= 1'b0;
            start_pulse_q <= 1'b0;
            state_q       <= IDLE;
            dir_q         <= 2'd0;
            move_pulse_q  <= '0;
            locked_q      <= 1'b0;
            code_q        <= 2'd0;
`ifdef MOVE_AUTO_REPEAT_EN
            timer_q       <= '0;
`endif
        end else begin
            sync1_q       <= sync1_d;
            sync2_q       <= sync2_d;
            deb_q         <= deb_d;
            for (int i = 0; i < N_IN; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
            start_prev_q  <= start_prev_d;
            start_pulse_q <= start_pulse_d;
            state_q       <= state_d;
            dir_q         <= dir_d;
            move_pulse_q  <= move_pulse_d;
            locked_q      <= locked_d;
            code_q        <= code_d;
`ifdef MOVE_AUTO_REPEAT_EN
            timer_q       <= timer_d;
`endif
        end
    end

    assign o_Up_Pulse    = move_pulse_q[0];
    assign o_Down_Pulse  = move_pulse_q[1];
    assign o_Left_Pulse  = move_pulse_q[2];
    assign o_Right_Pulse = move_pulse_q[3];
    assign o_Start_Pulse = start_pulse_q;
    assign o_Locked      = locked_q;
    assign o_Dir_Code    = code_q;

endmodule

// File: tb/tb_move_input_cond.sv
`timescale 1ns/1ps
// tb_move_input_cond: directed and randomized bench for move_input_cond.
// The reference model tracks raw-level history, debounced levels, the owned
// direction and the absolute cycle at which the next repeat is due.
module tb_move_input_cond;
    localparam int DEB    = 4;
    localparam int RDELAY = 10;
    localparam int RRATE  = 5;
`ifdef MOVE_AUTO_REPEAT_EN
    localparam bit AUTO = 1'b1;
`else
    localparam bit AUTO = 1'b0;
`endif

    logic       clk   = 1'b0;
    logic       rst   = 1'b1;
    logic       start = 1'b0;
    logic       up    = 1'b0;
    logic       down  = 1'b0;
    logic       left  = 1'b0;
    logic       right = 1'b0;
    logic       en    = 1'b0;
    logic       up_p, down_p, left_p, right_p, start_p, locked;
    logic [1:0] dir_code;
    logic [7:0] dut_vec;

    int pass_cnt  = 0;
    int check_cnt = 0;

    // reference model state
    int         t              = 0;
    logic [4:0] past1          = '0;
    logic [4:0] past2          = '0;
    logic [4:0] deb            = '0;
    int         run [5]        = '{default: 0};
    logic       prev_deb_start = 1'b0;
    int         owner          = -1;
    int         next_fire      = 0;
    logic [7:0] exp_vec        = '0;

    move_input_cond #(
        .c_DEBOUNCE_LIMIT(DEB),
        .c_REPEAT_DELAY  (RDELAY),
        .c_REPEAT_RATE   (RRATE)
    ) dut (
        .i_Clk        (clk),
        .i_Reset      (rst),
        .i_Game_Start (start),
        .i_Up_Mvt     (up),
        .i_Down_Mvt   (down),
        .i_Left_Mvt   (left),
        .i_Right_Mvt  (right),
        .i_Enable     (en),
        .o_Up_Pulse   (up_p),
        .o_Down_Pulse (down_p),
        .o_Left_Pulse (left_p),
        .o_Right_Pulse(right_p),
        .o_Start_Pulse(start_p),
        .o_Locked     (locked),
        .o_Dir_Code   (dir_code)
    );

    always #5 clk = ~clk;

    assign dut_vec = {start_p, up_p, down_p, left_p, right_p, locked, dir_code};

    // One clock edge of the behavioural model, using the inputs sampled at that edge
    task automatic model_edge();
        logic [4:0] raw;
        logic       exp_start;
        int         fired;
        raw = {start, right, left, down, up};
        if (rst) begin
            past1 = '0; past2 = '0; deb = '0;
            for (int i = 0; i < 5; i++) run[i] = 0;
            prev_deb_start = 1'b0;
            owner   = -1;
            exp_vec = '0;
        end else begin
            exp_start      = deb[4] && !prev_deb_start;
            prev_deb_start = deb[4];
            fired = -1;
            if (!en) begin
                owner = -1;
            end else if (owner < 0) begin
                for (int d = 0; d < 4; d++) if (fired < 0 && deb[d]) fired = d;
                if (fired >= 0) begin
                    owner     = fired;
                    next_fire = t + RDELAY;
                end
            end else if (!deb[owner]) begin
                owner = -1;
            end else if (AUTO && t == next_fire) begin
                fired     = owner;
                next_fire = t + RRATE;
            end
            // a level is accepted once the twice-delayed input disagrees for DEB+1 edges in a row
            for (int i = 0; i < 5; i++) begin
                if (past2[i] != deb[i]) begin
                    run[i]++;
                    if (run[i] == DEB + 1) begin
                        deb[i] = ~deb[i];
                        run[i] = 0;
                    end
                end else begin
                    run[i] = 0;
                end
            end
            past2 = past1;
            past1 = raw;
            exp_vec = {exp_start, fired == 0, fired == 1, fired == 2, fired == 3,
                       owner >= 0, (owner >= 0) ? 2'(owner) : 2'd0};
        end
        t++;
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic settle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        {start, up, down, left, right, en} = '0;
        for (int c = 0; c < 3; c++) begin
            step();
            check_cnt++;
            if (dut_vec !== 8'h00) $display("[TB] FAIL reset_state c=%0d got %b want %b", c, dut_vec, 8'h00);
            else pass_cnt++;
        end
        rst = 1'b0;
        for (int c = 0; c < 4; c++) begin
            step();
            check_cnt++;
            if (dut_vec !== exp_vec) $display("[TB] FAIL reset_model c=%0d got %b want %b", c, dut_vec, exp_vec);
            else pass_cnt++;
        end
    endtask

    task automatic test_hold_up();
        logic exp_up;
        en = 1'b1;
        up = 1'b1;
        for (int c = 0; c < 30; c++) begin
            step();
            exp_up = (c == 7) || (AUTO && (c == 17 || c == 22 || c == 27));
            check_cnt++;
            if ({up_p, locked} !== {exp_up, c >= 7})
                $display("[TB] FAIL hold_up c=%0d got up/locked=%b%b want %b%b", c, up_p, locked, exp_up, c >= 7);
            else pass_cnt++;
            check_cnt++;
            if (dut_vec !== exp_vec) $display("[TB] FAIL hold_up_model c=%0d got %b want %b", c, dut_vec, exp_vec);
            else pass_cnt++;
        end
        up = 1'b0;
        for (int c = 0; c < 12; c++) begin
            step();
            check_cnt++;
            if (dut_vec !== exp_vec) $display("[TB] FAIL up_release c=%0d got %b want %b", c, dut_vec, exp_vec);
            else pass_cnt++;
        end
        check_cnt++;
        if (locked !== 1'b0) $display("[TB] FAIL up_unlock got %b want 0", locked);
        else pass_cnt++;
    endtask

    task automatic test_glitch();
        for (int c = 0; c < 15; c++) begin
            left = (c < 3);
            step();
            check_cnt++;
            if ({left_p, locked} !== 2'b00) $display("[TB] FAIL glitch c=%0d got left/locked=%b%b want 00", c, left_p, locked);
            else pass_cnt++;
            check_cnt++;
            if (dut_vec !== exp_vec) $display("[TB] FAIL glitch_model c=%0d got %b want %b", c, dut_vec, exp_vec);
            else pass_cnt++;
        end
        left = 1'b0;
    endtask

    task automatic test_simultaneous();
        logic [1:0] exp_dir;
        down  = 1'b1;
        right = 1'b1;
        for (int c = 0; c < 10; c++) begin
            step();
            check_cnt++;
            if ({down_p, right_p} !== {c == 7, 1'b0})
                $display("[TB] FAIL simul_press c=%0d got down/right=%b%b want %b0", c, down_p, right_p, c == 7);
            else pass_cnt++;
            check_cnt++;
            if (dut_vec !== exp_vec) $display("[TB] FAIL simul_model c=%0d got %b want %b", c, dut_vec, exp_vec);
            else pass_cnt++;
        end
        down = 1'b0;
        for (int c = 0; c < 12; c++) begin
            step();
            exp_dir = (c < 7) ? 2'd1 : ((c == 7) ? 2'd0 : 2'd3);
            check_cnt++;
            if ({right_p, down_p, locked, dir_code} !== {c == 8, 1'b0, c != 7, exp_dir})
                $display("[TB] FAIL handover c=%0d got right/down/locked/dir=%b%b%b%0d want %b0%b%0d",
                         c, right_p, down_p, locked, dir_code, c == 8, c != 7, exp_dir);
            else pass_cnt++;
            check_cnt++;
            if (dut_vec !== exp_vec) $display("[TB] FAIL handover_model c=%0d got %b want %b", c, dut_vec, exp_vec);
            else pass_cnt++;
        end
        right = 1'b0;
        settle(15);
    endtask

    task automatic test_enable();
        en    = 1'b0;
        up    = 1'b1;
        start = 1'b1;
        for (int c = 0; c < 12; c++) begin
            step();
            check_cnt++;
            if ({up_p, down_p, left_p, right_p, start_p} !== {4'b0000, c == 7})
                $display("[TB] FAIL enable_low c=%0d got moves/start=%b%b%b%b%b want 0000%b",
                         c, up_p, down_p, left_p, right_p, start_p, c == 7);
            else pass_cnt++;
            check_cnt++;
            if (dut_vec !== exp_vec) $display("[TB] FAIL enable_model c=%0d got %b want %b", c, dut_vec, exp_vec);
            else pass_cnt++;
        end
        en = 1'b1;
        step();
        check_cnt++;
        if ({up_p, locked} !== 2'b11) $display("[TB] FAIL enable_rise got up/locked=%b%b want 11", up_p, locked);
        else pass_cnt++;
        up    = 1'b0;
        start = 1'b0;
        settle(15);
    endtask

    task automatic test_reset_mid();
        en = 1'b1;
        up = 1'b1;
        settle(20);
        check_cnt++;
        if (locked !== 1'b1) $display("[TB] FAIL pre_reset_lock got %b want 1", locked);
        else pass_cnt++;
        rst = 1'b1;
        step();
        check_cnt++;
        if (dut_vec !== 8'h00) $display("[TB] FAIL mid_reset got %b want %b", dut_vec, 8'h00);
        else pass_cnt++;
        rst = 1'b0;
        for (int c = 0; c < 10; c++) begin
            step();
            check_cnt++;
            if (up_p !== (c == 7)) $display("[TB] FAIL post_reset c=%0d got up=%b want %b", c, up_p, c == 7);
            else pass_cnt++;
            check_cnt++;
            if (dut_vec !== exp_vec) $display("[TB] FAIL post_reset_model c=%0d got %b want %b", c, dut_vec, exp_vec);
            else pass_cnt++;
        end
        up = 1'b0;
        settle(15);
    endtask

    task automatic test_single_shot();
        int count = 0;
        en    = 1'b1;
        right = 1'b1;
        for (int c = 0; c < 100; c++) begin
            step();
            if (right_p === 1'b1) count++;
            if (c == 7) begin
                check_cnt++;
                if (right_p !== 1'b1) $display("[TB] FAIL first_right got %b want 1", right_p);
                else pass_cnt++;
            end
            check_cnt++;
            if (dut_vec !== exp_vec) $display("[TB] FAIL hold_right_model c=%0d got %b want %b", c, dut_vec, exp_vec);
            else pass_cnt++;
        end
        check_cnt++;
        if (count !== (AUTO ? 18 : 1)) $display("[TB] FAIL right_count got %0d want %0d", count, AUTO ? 18 : 1);
        else pass_cnt++;
        right = 1'b0;
        settle(15);
    endtask

    task automatic test_random();
        en = 1'b1;
        for (int s = 0; s < 90; s++) begin
            int len;
            len = $urandom_range(1, 12);
            {start, right, left, down, up} = 5'($urandom);
            if ($urandom_range(0, 9) == 0) en = ~en;
            rst = ($urandom_range(0, 29) == 0);
            for (int k = 0; k < len; k++) begin
                step();
                rst = 1'b0;
                check_cnt++;
                if (dut_vec !== exp_vec) $display("[TB] FAIL random s=%0d k=%0d got %b want %b", s, k, dut_vec, exp_vec);
                else pass_cnt++;
            end
        end
        {start, right, left, down, up} = '0;
        settle(15);
    endtask

    initial begin
        test_reset();
        test_hold_up();
        settle(5);
        test_glitch();
        test_simultaneous();
        test_enable();
        test_reset_mid();
        test_single_shot();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
